// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side bus for the data and instruction ports
interface sram_arbiter_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  modport master(output d_req, d_we, d_addr, d_wdata, i_req, i_addr, input d_ready, d_rdata, i_ready, i_rdata);
  modport slave(input d_req, d_we, d_addr, d_wdata, i_req, i_addr, output d_ready, d_rdata, i_ready, i_rdata);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin share of a 16-bit SRAM, each 32-bit access split into LO/HI half-word phases
module sram_arbiter #(
  parameter int          ACCESS_CYC = 2,
  parameter logic [31:0] D_BASE     = 32'd1024,
  parameter logic [31:0] I_BASE     = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  inout  wire  [15:0]       SRAM_data,
  output logic [17:0]       SRAM_addr,
  output logic              SRAM_WE_N
);
  localparam int CW = ACCESS_CYC > 1 ? $clog2(ACCESS_CYC) : 1;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          fin, any, gnt_i, dw, port, we, lg, drv;
  logic [17:0]   a, ga;
  logic [15:0]   whi, dout, rlo;
  assign SRAM_data = drv ? dout : 16'hzzzz;
  always_comb begin
    any   = bus.d_req | bus.i_req;
    gnt_i = bus.i_req & (!bus.d_req | !lg);
    dw    = !gnt_i & bus.d_we;
    ga    = gnt_i ? 18'((bus.i_addr - I_BASE) >> 1) : 18'((bus.d_addr - D_BASE) >> 1);
    fin   = cnt == CW'(ACCESS_CYC - 1);
    nxt   = state == IDLE ? (any ? LO : IDLE) :
            state == LO   ? (fin ? HI : LO) :
            state == HI   ? (fin ? DONE : HI) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      port        <= 1'b0;
      we          <= 1'b0;
      lg          <= 1'b1;
      a           <= '0;
      whi         <= '0;
      dout        <= '0;
      rlo         <= '0;
      drv         <= 1'b0;
      SRAM_addr   <= '0;
      SRAM_WE_N   <= 1'b1;
      bus.d_ready <= 1'b0;
      bus.i_ready <= 1'b0;
      bus.d_rdata <= '0;
      bus.i_rdata <= '0;
    end else begin
      cnt         <= (state == LO || state == HI) && !fin ? cnt + 1'b1 : '0;
      bus.d_ready <= 1'b0;
      bus.i_ready <= 1'b0;
      if (state == IDLE && any) begin
        port      <= gnt_i;
        we        <= dw;
        a         <= ga;
        whi       <= bus.d_wdata[31:16];
        dout      <= bus.d_wdata[15:0];
        drv       <= dw;
        SRAM_addr <= ga;
        SRAM_WE_N <= !dw;
      end
      if (state == LO && fin) begin
        rlo       <= SRAM_data;
        dout      <= whi;
        SRAM_addr <= a | 18'd1;
      end
      // ready and read data are registered so both are visible throughout DONE
      if (state == HI && fin) begin
        drv         <= 1'b0;
        SRAM_WE_N   <= 1'b1;
        bus.d_ready <= !port;
        bus.i_ready <= port;
        if (!we && port) bus.i_rdata <= {SRAM_data, rlo};
        if (!we && !port) bus.d_rdata <= {SRAM_data, rlo};
      end
      if (state == DONE) lg <= port;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with a queue scoreboard checked by a ready monitor
module tb_sram_arbiter;
  localparam int          ACC = 2;
  localparam logic [31:0] DB  = 32'd1024;
  localparam logic [31:0] IB  = 32'd0;
  typedef struct {logic p; logic [31:0] d; int c;} exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] SRAM_data;
  logic [17:0] SRAM_addr;
  logic        SRAM_WE_N;
  logic [15:0] mem [0:7];
  exp_t        sbq [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] d_last = 32'd0;
  logic [31:0] i_last = 32'd0;
  sram_arbiter_if bif();
  sram_arbiter #(.ACCESS_CYC(ACC), .D_BASE(DB), .I_BASE(IB)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave),
    .SRAM_data(SRAM_data), .SRAM_addr(SRAM_addr), .SRAM_WE_N(SRAM_WE_N)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign SRAM_data = SRAM_WE_N ? mem[SRAM_addr[2:0]] : 16'hzzzz;
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
      mem[4] <= 16'h0001;
      mem[5] <= 16'hE3A0;
    end else if (!SRAM_WE_N) mem[SRAM_addr[2:0]] <= SRAM_data;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && (bif.d_ready || bif.i_ready)) begin
      exp_t e;
      chk("one_ready", {31'd0, bif.d_ready & bif.i_ready}, 32'd0);
      if (sbq.size() == 0) chk("unexpected_ready", {31'd0, bif.i_ready}, {31'd0, !bif.d_ready});
      else begin
        e = sbq.pop_front();
        chk("ready_port", {31'd0, bif.i_ready}, {31'd0, e.p});
        chk("rdata", e.p ? bif.i_rdata : bif.d_rdata, e.d);
        chk("ready_cycle", cyc, e.c);
      end
    end
  task automatic xact(input logic p, input logic w, input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] er);
    int k;
    logic [17:0] a;
    logic got;
    logic [31:0] ex;
    @(posedge clk); #1;
    if (p) begin bif.i_req = 1'b1; bif.i_addr = ad; end
    else begin bif.d_req = 1'b1; bif.d_we = w; bif.d_addr = ad; bif.d_wdata = wd; end
    k = cyc;
    a = 18'((ad - (p ? IB : DB)) >> 1);
    ex = w ? d_last : er;
    if (!w && p) i_last = er;
    if (!w && !p) d_last = er;
    sbq.push_back('{p, ex, k + 2 * ACC + 1});
    got = 1'b0;
    for (int j = 0; j < 60 && !got; j++) begin
      @(negedge clk);
      if (j >= 1 && j <= 2 * ACC) begin
        chk("sram_addr", {14'd0, SRAM_addr}, {14'd0, j <= ACC ? a : a | 18'd1});
        chk("sram_we_n", {31'd0, SRAM_WE_N}, {31'd0, !w});
        if (w) chk("sram_wdata", {16'd0, SRAM_data}, {16'd0, j <= ACC ? wd[15:0] : wd[31:16]});
      end
      got = bif.d_ready | bif.i_ready;
    end
    chk("ready_seen", {31'd0, got}, 32'd1);
    bif.d_req = 1'b0;
    bif.i_req = 1'b0;
  endtask
  for (genvar g = 0; g < 2; g++) begin : side
    localparam int AC = g ? 4 : 1;
    sram_arbiter_if sif();
    wire  [15:0] sd;
    logic [17:0] sa;
    logic        sw;
    bit          done = 1'b0;
    assign sd = sw ? (sa == 18'd4 ? 16'h0001 : sa == 18'd5 ? 16'hE3A0 : 16'h0000) : 16'hzzzz;
    sram_arbiter #(.ACCESS_CYC(AC)) u (
      .clk(clk), .rst(rst), .bus(sif.slave), .SRAM_data(sd), .SRAM_addr(sa), .SRAM_WE_N(sw)
    );
    initial begin
      int n;
      sif.d_req = 1'b0; sif.d_we = 1'b0; sif.d_addr = '0; sif.d_wdata = '0;
      sif.i_req = 1'b0; sif.i_addr = '0;
      repeat (5) @(posedge clk);
      #1 sif.d_req = 1'b1; sif.d_addr = 32'd1032;
      for (n = 0; n < 60; n++) begin
        @(negedge clk);
        if (sif.d_ready) break;
      end
      chk($sformatf("latency_ac%0d", AC), n, 2 * AC + 1);
      chk($sformatf("rdata_ac%0d", AC), sif.d_rdata, 32'hE3A00001);
      sif.d_req = 1'b0;
      done = 1'b1;
    end
  end
  initial begin
    int k, cnt;
    bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_addr = '0; bif.d_wdata = '0;
    bif.i_req = 1'b0; bif.i_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_d_ready", {31'd0, bif.d_ready}, 32'd0);
    chk("rst_i_ready", {31'd0, bif.i_ready}, 32'd0);
    chk("rst_d_rdata", bif.d_rdata, 32'd0);
    chk("rst_i_rdata", bif.i_rdata, 32'd0);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_addr", {14'd0, SRAM_addr}, 32'd0);
    xact(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0);
    xact(1'b0, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF);
    xact(1'b1, 1'b0, 32'd8, 32'd0, 32'hE3A00001);
    @(posedge clk); #1;
    bif.d_we = 1'b0; bif.d_addr = 32'd1024; bif.i_addr = 32'd8;
    bif.d_req = 1'b1; bif.i_req = 1'b1;
    k = cyc;
    for (int n = 0; n < 4; n++)
      sbq.push_back('{n[0], n[0] ? 32'hE3A00001 : 32'hDEADBEEF, k + (2 * ACC + 1) + (2 * ACC + 2) * n});
    cnt = 0;
    for (int j = 0; j < 100 && cnt < 4; j++) begin
      @(negedge clk);
      if (bif.d_ready | bif.i_ready) cnt++;
    end
    chk("tie_count", cnt, 32'd4);
    bif.d_req = 1'b0; bif.i_req = 1'b0;
    @(posedge clk); #1;
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 32'd1024; bif.d_wdata = 32'h12345678;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bif.d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("abort_no_ready", {31'd0, bif.d_ready}, 32'd0);
    chk("abort_d_rdata", bif.d_rdata, 32'd0);
    d_last = 32'd0;
    i_last = 32'd0;
    xact(1'b0, 1'b0, 32'd1032, 32'd0, 32'hE3A00001);
    xact(1'b0, 1'b1, 32'd1024 + 32'd524288, 32'hCAFEF00D, 32'd0);
    xact(1'b0, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D);
    xact(1'b1, 1'b0, 32'd8, 32'd0, 32'hE3A00001);
    for (int j = 0; j < 200 && !(side[0].done && side[1].done); j++) @(negedge clk);
    chk("side_done", {31'd0, side[0].done & side[1].done}, 32'd1);
    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 16-bit external SRAM between the MEM stage data port and an instruction-fetch port. Grants one 32-bit access at a time with round-robin tie-breaking, and runs each access as two SRAM half-word phases. Returns a one-cycle ready pulse to the winning requester. Sits between the pipeline's memory-side requesters and the SRAM pins, replacing direct ownership of the SRAM by the MEM stage.

## Interface
Parameters:
- ACCESS_CYC, 2, cycles each half-word phase is held (minimum 1)
- D_BASE, 32'd1024, byte address mapped to SRAM half-word 0 for the data port
- I_BASE, 32'd0, byte address mapped to SRAM half-word 0 for the instruction port

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- d_req  in  1  data port request; held until d_ready
- d_we  in  1  data port write (1) / read (0)
- d_addr  in  32  data byte address, word-aligned
- d_wdata  in  32  data store value
- d_ready  out  1  one-cycle completion pulse, data port
- d_rdata  out  32  data load result
- i_req  in  1  instruction port read request; held until i_ready
- i_addr  in  32  instruction byte address, word-aligned
- i_ready  out  1  one-cycle completion pulse, instruction port
- i_rdata  out  32  fetched word
- SRAM_data  inout  16  SRAM data bus
- SRAM_addr  out  18  SRAM half-word address
- SRAM_WE_N  out  1  SRAM write enable, active-low

## Operation
- Address map: A = (addr − BASE) >> 1, using 32-bit wrap-around subtraction. The LO phase uses A[17:0], the HI phase uses A[17:0] | 1. Bits above 17 are discarded.
- FSM states: IDLE → LO → HI → DONE → IDLE.
- IDLE:
  - Only one request pending: grant that port.
  - Both pending: grant the port not in last_grant.
  - None pending: stay in IDLE.
  - On grant, latch port, we (forced 0 for the instruction port), A, and wdata, then go to LO.
- LO and HI: each lasts exactly ACCESS_CYC cycles, counted by a phase counter. SRAM_addr is held stable for the whole phase.
- Write:
  - LO drives wdata[15:0] on SRAM_data; HI drives wdata[31:16].
  - SRAM_WE_N is 0 for every cycle of both phases.
- Read:
  - SRAM_data is 16'bz and SRAM_WE_N is 1.
  - The last cycle of LO captures SRAM_data into the low half of the result; the last cycle of HI captures it into the high half.
- DONE:
  - Exactly one cycle. Assert ready for the granted port only.
  - For a read, load the assembled word into that port's rdata.
  - Update last_grant.
- d_rdata and i_rdata hold their value until that port's next read completes. A write leaves d_rdata unchanged.
- Outside write phases: SRAM_data = 16'bz and SRAM_WE_N = 1. In IDLE and DONE, SRAM_addr holds its last value.
- Request signals are sampled only in IDLE. Changes to a request mid-transaction are ignored.

## Timing
- Reset values: state IDLE, counter 0, last_grant = instruction (so the first tie goes to data), d_ready = i_ready = 0, d_rdata = i_rdata = 0, SRAM_WE_N = 1, SRAM_addr = 0, SRAM_data = z.
- Latency: a request seen in IDLE at cycle t gives a ready pulse in cycle t + 2·ACCESS_CYC + 1. With the default ACCESS_CYC = 2, this is t + 5.
- Ready is a pulse. The requester advances on that edge, and its next request is sampled in the following IDLE cycle. Back-to-back transactions are therefore 2·ACCESS_CYC + 2 cycles apart.
- Both requests held continuously: grants alternate D, I, D, I…
- One request held, the other idle: the held port is served back-to-back with no penalty.
- rst asserted in any state:
  - The next edge returns everything to the reset values, including ending any in-flight write phase.
  - A partially written word is permitted. The aborted requester gets no ready pulse.
- rst dominates request inputs in the same cycle.

## Test plan
- Single data write then read: d_addr = 1024, d_wdata = 32'hDEADBEEF, then a read of 1024.
  - Write: SRAM_addr = 0 for 2 cycles with data 16'hBEEF, then SRAM_addr = 1 with data 16'hDEAD, SRAM_WE_N low for 4 cycles, d_ready pulses at t+5.
  - Read: d_rdata = 32'hDEADBEEF at d_ready.
- Instruction fetch: i_addr = 8, SRAM model holds half-words 4 = 16'h0001 and 5 = 16'hE3A0.
  - i_ready pulses at t+5 with i_rdata = 32'hE3A00001.
  - SRAM_WE_N stays 1 throughout; SRAM_data stays z.
- Simultaneous d_req and i_req out of reset, held for 4 transactions.
  - Grant order D, I, D, I.
  - Ready pulses 6 cycles apart, never both ready in one cycle.
- Reset mid-write: assert rst during the HI phase of a write.
  - Next cycle: SRAM_WE_N = 1, SRAM_data = z, FSM in IDLE, no d_ready.
  - A fresh read then completes normally.
- ACCESS_CYC = 1 and ACCESS_CYC = 4 builds: ready at t+3 and t+9 respectively, with read data correct.
- Address wrap: d_addr = 1024 + 2^19.
  - SRAM_addr = 0 then 1, because A is truncated to 18 bits.
